// File: rtl/conv_encoder.sv
// ----------------------------------------------------------------------------
// conv_encoder
//   Rate 1/2, constraint length 3 convolutional encoder with generator
//   polynomials g0 = 111 and g1 = 101. One information bit in, one coded
//   two-bit symbol out, with valid/ready handshakes on both sides and a
//   single registered output stage (one cycle latency, full throughput).
//
//   Build option:
//     CONV_ENCODER_TAIL_FLUSH_EN  defined   -> each frame is terminated with
//                                              two zero tail bits, so the
//                                              trellis ends in state 00 and
//                                              out_last marks the 2nd tail.
//                                 undefined -> no tail; out_last marks the
//                                              symbol of the in_last bit and
//                                              the shift register is cleared.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_bit     in   information bit
//     in_valid   in   in_bit/in_last valid
//     in_last    in   in_bit is the final data bit of the frame
//     in_ready   out  encoder accepts input this cycle
//     tx_pair    out  coded symbol, [1] = g0 bit, [0] = g1 bit
//     out_valid  out  tx_pair/out_last valid
//     out_last   out  final symbol of the frame
//     out_ready  in   downstream accepts the symbol
//     busy       out  frame in progress or symbol pending
// ----------------------------------------------------------------------------
module conv_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] tx_pair,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DATA  = 2'b01,
    ST_TAIL0 = 2'b10,
    ST_TAIL1 = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic       s1_q, s1_d;
  logic       s0_q, s0_d;
  logic [1:0] tx_pair_q, tx_pair_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;

  logic       out_free;
  logic       in_ready_int;
  logic       accept;

  // Both generator outputs are parities over taps of {u, s1, s0}.
  function automatic logic [1:0] encode(input logic u, input logic s1, input logic s0);
    encode = {u ^ s1 ^ s0, u ^ s0};
  endfunction

  // Handshake qualifiers: the output register can take a new symbol when it
  // is empty or being drained this cycle; input is held off during reset.
  always_comb begin
    out_free     = !out_valid_q || out_ready;
    in_ready_int = rst_n && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && out_free;
    accept       = in_valid && in_ready_int;
  end

  // Next-state logic for the FSM, shift register and output register.
  always_comb begin
    state_d   = state_q;
    s1_d      = s1_q;
    s0_d      = s0_q;
    tx_pair_d = tx_pair_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
    end

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          tx_pair_d   = encode(in_bit, s1_q, s0_q);
          out_valid_d = 1'b1;
          if (in_last) begin
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
            state_d    = ST_TAIL0;
            s1_d       = in_bit;
            s0_d       = s1_q;
            out_last_d = 1'b0;
`else
            // No tail: clear the register so the next frame starts at 00.
            state_d    = ST_IDLE;
            s1_d       = 1'b0;
            s0_d       = 1'b0;
            out_last_d = 1'b1;
`endif
          end else begin
            state_d    = ST_DATA;
            s1_d       = in_bit;
            s0_d       = s1_q;
            out_last_d = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_TAIL0: begin
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
        if (out_free) begin
          tx_pair_d   = encode(1'b0, s1_q, s0_q);
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          s1_d        = 1'b0;
          s0_d        = s1_q;
          state_d     = ST_TAIL1;
        end else begin
          state_d = ST_TAIL0;
        end
`else
        state_d = ST_IDLE;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
`endif
      end
      ST_TAIL1: begin
`ifdef CONV_ENCODER_TAIL_FLUSH_EN
        if (out_free) begin
          // s1 is already 0 here, so both taps end at 0 after this encode.
          tx_pair_d   = encode(1'b0, s1_q, s0_q);
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          s1_d        = 1'b0;
          s0_d        = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_TAIL1;
        end
`else
        state_d = ST_IDLE;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || out_valid_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s1_q        <= 1'b0;
      s0_q        <= 1'b0;
      tx_pair_q   <= 2'b00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      tx_pair_q   <= tx_pair_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign tx_pair   = tx_pair_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder.sv
// ----------------------------------------------------------------------------
// tb_conv_encoder
//   Self-checking bench for conv_encoder. The reference is a stream model:
//   every accepted bit is turned into its symbol(s) from the frame's bit
//   history, queued, and the DUT output register must always present the
//   queue head. Directed frames are additionally compared to literal symbol
//   lists. Works for both the flush and non-flush builds.
// ----------------------------------------------------------------------------
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [1:0] tx_pair;
  logic       out_valid;
  logic       out_last;
  logic       busy;

`ifdef CONV_ENCODER_TAIL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  conv_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_pair  (tx_pair),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] exp_q[$];      // {last, pair} still to be delivered
  bit         frame_bits[$]; // bits of the currently open frame
  bit         in_frame = 1'b0;
  bit         last_acc;
  logic [2:0] got[$];        // {last, pair} actually consumed from the DUT
  int         got_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] sym(input bit u, input bit p1, input bit p2);
    return {u ^ p1 ^ p2, u ^ p2};
  endfunction

  // Model: translate one accepted bit into the symbols it causes.
  task automatic model_bit(input bit u, input bit last);
    int n;
    bit p1, p2;
    n  = frame_bits.size();
    p1 = (n >= 1) ? frame_bits[n-1] : 1'b0;
    p2 = (n >= 2) ? frame_bits[n-2] : 1'b0;
    if (last && FLUSH) begin
      exp_q.push_back({1'b0, sym(u, p1, p2)});
      exp_q.push_back({1'b0, sym(1'b0, u, p1)});
      exp_q.push_back({1'b1, sym(1'b0, 1'b0, u)});
    end else begin
      exp_q.push_back({last, sym(u, p1, p2)});
    end
    if (last) begin
      frame_bits.delete();
      in_frame = 1'b0;
    end else begin
      frame_bits.push_back(u);
      in_frame = 1'b1;
    end
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic step();
    bit exp_rdy, cons;
    #1;
    exp_rdy = rst_n && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
    chk("in_ready", in_ready, exp_rdy);
    last_acc = in_valid && exp_rdy;
    cons     = (exp_q.size() != 0) && out_ready;
    if (out_valid && out_ready) begin
      got.push_back({out_last, tx_pair});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (cons) void'(exp_q.pop_front());
    if (last_acc) model_bit(in_bit, in_last);
    @(negedge clk);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("busy", busy, (exp_q.size() != 0) || in_frame);
    if (exp_q.size() != 0) begin
      chk("tx_pair", tx_pair, exp_q[0][1:0]);
      chk("out_last", out_last, exp_q[0][2]);
    end
  endtask

  task automatic send_bit(input bit b, input bit l);
    int n;
    in_bit   = b;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: bit never accepted after %0d cycles", n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d symbols still pending", exp_q.size());
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
  endtask

  task automatic check_seq(input string name, input logic [2:0] exp[$], input bit contig);
    chk({name, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) begin
        chk(name, got[i], exp[i]);
        if (contig) chk({name, "_cyc"}, got_cyc[i] - got_cyc[0], i);
      end
    end
  endtask

  logic [2:0] ref_seq[$];

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_tx_pair", tx_pair, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Frame 1,0,1,1(last) at full throughput
    clear_log();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    drain();
    if (FLUSH) ref_seq = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    else       ref_seq = '{3'b011, 3'b010, 3'b000, 3'b101};
    check_seq("frame1011", ref_seq, 1'b1);
    chk("frame1011_busy_after", busy, 1'b0);

    // Next frame single bit 1: state must have been cleared
    clear_log();
    send_bit(1'b1, 1'b1);
    if (FLUSH) begin
      // Both tail cycles must refuse input
      step();
      chk("tail_in_ready0", in_ready, 1'b0);
      step();
      chk("tail_in_ready1", in_ready, 1'b0);
    end
    drain();
    if (FLUSH) ref_seq = '{3'b011, 3'b010, 3'b111};
    else       ref_seq = '{3'b111};
    check_seq("single_bit", ref_seq, 1'b1);

    // Backpressure: stall 3 cycles after the first symbol
    clear_log();
    send_bit(1'b1, 1'b0);
    out_ready = 1'b0;
    in_bit    = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pair", tx_pair, 2'b11);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    drain();
    if (FLUSH) ref_seq = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    else       ref_seq = '{3'b011, 3'b010, 3'b000, 3'b101};
    check_seq("backpressure", ref_seq, 1'b0);

    // Back-to-back single-bit frames
    clear_log();
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    drain();
    if (FLUSH) ref_seq = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b111};
    else       ref_seq = '{3'b111, 3'b111};
    check_seq("back_to_back", ref_seq, 1'b1);

    // Asynchronous reset in the middle of a frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    exp_q.delete();
    frame_bits.delete();
    in_frame = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send_bit(1'b0, 1'b1);
    drain();
    if (FLUSH) ref_seq = '{3'b000, 3'b000, 3'b100};
    else       ref_seq = '{3'b100};
    check_seq("after_reset", ref_seq, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(99, 0) < 70);
      in_bit    = $urandom_range(1, 0);
      in_last   = ($urandom_range(7, 0) == 0);
      out_ready = ($urandom_range(99, 0) < 75);
      step();
    end
    out_ready = 1'b1;
    in_last   = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
